// File: rtl/demux_scheduler_if.sv
// Bundle of the producer-side and consumer-side signals of demux_scheduler.
// The scheduler uses the slave modport; the producer/consumer side uses master.
interface demux_scheduler_if #(
  parameter int W = 8
);
  logic         en;
  logic [3:0]   mask;
  logic         i_valid;
  logic [W-1:0] i_data;
  logic         i_ready;
  logic [3:0]   y_valid;
  logic [W-1:0] y_data;
  logic [3:0]   y_ready;
  logic [1:0]   s;
  logic         drop;

  modport master (
    output en, mask, i_valid, i_data, y_ready,
    input  i_ready, y_valid, y_data, s, drop
  );

  modport slave (
    input  en, mask, i_valid, i_data, y_ready,
    output i_ready, y_valid, y_data, s, drop
  );
endinterface

// File: rtl/demux_scheduler.sv
// Round-robin dispatcher for a 1-to-4 demux: holds one word and steers it to a masked channel.
// Optional hold timeout with drop pulse is enabled by defining DEMUX_SCHED_TIMEOUT_EN.
module demux_scheduler #(
  parameter int W = 8
`ifdef DEMUX_SCHED_TIMEOUT_EN
  , parameter int TO = 16
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  demux_scheduler_if.slave   bus
);

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t       state_q, state_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [1:0]   s_q, s_d;
  logic [W-1:0] data_q, data_d;
  logic [1:0]   grantBase, grant, idx;
  logic         iReady, accept, deliver;
`ifdef DEMUX_SCHED_TIMEOUT_EN
  logic [7:0]   waitCnt_q, waitCnt_d;
  logic         drop_q, drop_d;
  logic         timeout;
`endif

  assign deliver = (state_q == HOLD) && bus.y_ready[s_q];
  assign iReady  = rst_n && bus.en && (|bus.mask) && ((state_q == EMPTY) || bus.y_ready[s_q]);
  assign accept  = bus.i_valid && iReady;

  // An accept in HOLD always coincides with a delivery, so the search starts after s.
  always_comb begin
    grantBase = (state_q == HOLD) ? s_q + 2'd1 : ptr_q;
    grant     = grantBase;
    idx       = grantBase;
    for (int k = 3; k >= 0; k--) begin
      idx = grantBase + 2'(k);
      if (bus.mask[idx]) grant = idx;
    end
  end

`ifdef DEMUX_SCHED_TIMEOUT_EN
  assign timeout = (state_q == HOLD) && !bus.y_ready[s_q] && (waitCnt_q == 8'(TO - 1));
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    s_d     = s_q;
    data_d  = data_q;
`ifdef DEMUX_SCHED_TIMEOUT_EN
    drop_d    = 1'b0;
    waitCnt_d = waitCnt_q;
    if (state_q == HOLD && !bus.y_ready[s_q]) waitCnt_d = waitCnt_q + 8'd1;
    if (timeout) begin
      ptr_d   = s_q + 2'd1;
      state_d = EMPTY;
      drop_d  = 1'b1;
    end
`endif
    if (deliver) begin
      ptr_d   = s_q + 2'd1;
      state_d = EMPTY;
    end
    if (accept) begin
      data_d  = bus.i_data;
      s_d     = grant;
      state_d = HOLD;
`ifdef DEMUX_SCHED_TIMEOUT_EN
      waitCnt_d = 8'd0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= 2'd0;
      s_q     <= 2'd0;
      data_q  <= '0;
`ifdef DEMUX_SCHED_TIMEOUT_EN
      waitCnt_q <= 8'd0;
      drop_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      s_q     <= s_d;
      data_q  <= data_d;
`ifdef DEMUX_SCHED_TIMEOUT_EN
      waitCnt_q <= waitCnt_d;
      drop_q    <= drop_d;
`endif
    end
  end

  assign bus.i_ready = iReady;
  assign bus.y_valid = (state_q == HOLD) ? (4'b0001 << s_q) : 4'b0000;
  assign bus.y_data  = data_q;
  assign bus.s       = s_q;
`ifdef DEMUX_SCHED_TIMEOUT_EN
  assign bus.drop    = drop_q;
`else
  assign bus.drop    = 1'b0;
`endif

endmodule
